// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dmem_pkg;

  // Request size encoding
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Word index is placed at this bit position of mem_addr
  localparam int MEM_ADDR_SHIFT = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store lane merge, misalignment detect.
module lsu_align
  import dmem_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [1:0]   size,
  input  logic [1:0]   offset,
  input  logic         is_unsigned,
  input  logic [n-1:0] rdata,
  input  logic [n-1:0] merge_word,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] load_data,
  output logic [n-1:0] store_data,
  output logic         misaligned
);

  logic [n-1:0] shifted;

  // Byte lanes are little-endian, so shifting right by 8*offset right-aligns the addressed lane
  assign shifted = rdata >> {offset, 3'b000};

  // Misalignment: word needs offset 0, halfword needs even offset, size 3 is reserved
  always_comb begin
    // NOTE: a default on every path of an always_comb keeps synthesis from inferring a latch.
    misaligned = 1'b1;
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = (offset != 2'd0);
      default: misaligned = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane and sign- or zero-extend it
  always_comb begin
    load_data = shifted;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {{(n-8){1'b0}}, shifted[7:0]}
                                       : {{(n-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {{(n-16){1'b0}}, shifted[15:0]}
                                       : {{(n-16){shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Store path: replace only the addressed lane of the previously read word
  always_comb begin
    store_data = merge_word;
    case (size)
      SZ_BYTE: store_data[{offset, 3'b000} +: 8]   = wdata[7:0];
      SZ_HALF: store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the datapath and a word-addressed data memory.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata
);

  lsu_state_t   state, state_next;

  // Latched request; direction is carried by the state path, so it is not stored
  logic [1:0]   lat_size;
  logic         lat_uns;
  logic [n-1:0] lat_addr;
  logic [n-1:0] lat_wdata;
  logic [n-1:0] merge_q;

  logic [1:0]   cur_size;
  logic [1:0]   cur_offset;
  logic         misaligned;
  logic         out_of_range;
  logic         req_err;
  logic [n-1:0] load_data;
  logic [n-1:0] store_data;
  logic [n-1:0] word_addr;

  // Error decode looks at the live request in IDLE and at the latched one afterwards
  assign cur_size     = (state == IDLE) ? req_size      : lat_size;
  assign cur_offset   = (state == IDLE) ? req_addr[1:0] : lat_addr[1:0];
  assign out_of_range = |req_addr[n-1:r+2];
  assign req_err      = misaligned | out_of_range;
  assign word_addr    = (lat_addr >> 2) << MEM_ADDR_SHIFT;

  assign req_ready = (state == IDLE) && !reset;

  lsu_align #(.n(n)) u_align (
    .size        (cur_size),
    .offset      (cur_offset),
    .is_unsigned (lat_uns),
    .rdata       (mem_rdata),
    .merge_word  (merge_q),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .store_data  (store_data),
    .misaligned  (misaligned)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and memory/response strobes, all decoded from state
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_next = RESP;
          else if (!req_we)            state_next = LOAD;
          else if (req_size == SZ_WORD) state_next = STORE;
          else                         state_next = RMW_RD;
        end
      end
      LOAD: begin
        mem_addr   = word_addr;
        state_next = RESP;
      end
      RMW_RD: begin
        mem_addr   = word_addr;
        state_next = STORE;
      end
      STORE: begin
        mem_addr   = word_addr;
        mem_we     = 1'b1;
        mem_wdata  = store_data;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latches, merge register and registered response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_size  <= SZ_BYTE;
      lat_uns   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      merge_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
          end
        end
        LOAD:    rsp_rdata <= load_data;
        RMW_RD:  merge_q   <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small behavioural data memory.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [128];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic        bd_we = 1'b0;
  logic [6:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  dmem_lsu #(.n(32), .r(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Memory model: combinational read, write on posedge, plus a backdoor preload port
  assign mem_rdata = mem[mem_addr[11:5]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_we) begin
      mem[mem_addr[11:5]] <= mem_wdata;
      wr_count            <= wr_count + 1;
      last_wr_addr        <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [6:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Issue one request, wait for its response, capture it and complete the handshake
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    handshake();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          w0;

  logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0]  e_size [4] = '{SZ_WORD, SZ_HALF, 2'd3, SZ_WORD};
  logic [31:0] e_addr [4] = '{32'h11, 32'h13, 32'h10, 32'h200};

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    check("rst_mem_we",    32'(mem_we), 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Word store then word load
    w0 = wr_count;
    do_txn(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("wst_lat",    32'(lat), 32'd2);
    check("wst_err",    32'(er), 32'd0);
    check("wst_writes", 32'(wr_count - w0), 32'd1);
    check("wst_addr",   last_wr_addr, 32'h80);
    check("wst_mem",    mem[4], 32'hDEADBEEF);
    do_txn(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("wld_lat",   32'(lat), 32'd2);
    check("wld_err",   32'(er), 32'd0);
    check("wld_rdata", rd, 32'hDEADBEEF);

    // Byte store with read-modify-write, then signed/unsigned byte loads
    poke(7'd4, 32'h11223344);
    w0 = wr_count;
    do_txn(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, rd, er, lat);
    check("bst_lat",    32'(lat), 32'd3);
    check("bst_writes", 32'(wr_count - w0), 32'd1);
    check("bst_mem",    mem[4], 32'h11AA3344);
    check("bst_rdata",  rd, 32'd0);
    do_txn(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, rd, er, lat);
    check("bld_s", rd, 32'hFFFFFFAA);
    do_txn(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, rd, er, lat);
    check("bld_u", rd, 32'h000000AA);
    do_txn(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, rd, er, lat);
    check("bld_lane3", rd, 32'h00000011);

    // Halfword loads and store
    poke(7'd4, 32'h80017FFE);
    do_txn(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("hld_lo_s", rd, 32'h00007FFE);
    do_txn(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, rd, er, lat);
    check("hld_hi_s", rd, 32'hFFFF8001);
    do_txn(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, rd, er, lat);
    check("hld_hi_u", rd, 32'h00008001);
    do_txn(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF, rd, er, lat);
    check("hst_lat", 32'(lat), 32'd3);
    check("hst_mem", mem[4], 32'hBEEF7FFE);

    // Highest valid word index
    do_txn(1'b1, SZ_WORD, 1'b0, 32'h1FC, 32'hCAFEF00D, rd, er, lat);
    check("top_wr_addr", last_wr_addr, 32'h00000FE0);
    do_txn(1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0, rd, er, lat);
    check("top_err",   32'(er), 32'd0);
    check("top_rdata", rd, 32'hCAFEF00D);

    // Error cases: misaligned word, misaligned half store, reserved size, index out of range
    w0 = wr_count;
    for (int i = 0; i < 4; i++) begin
      do_txn(e_we[i], e_size[i], 1'b0, e_addr[i], 32'h5A5A5A5A, rd, er, lat);
      check("err_flag",  32'(er), 32'd1);
      check("err_rdata", rd, 32'd0);
      check("err_lat",   32'(lat), 32'd1);
    end
    check("err_no_write", 32'(wr_count - w0), 32'd0);

    // Back-pressure: response held 5 cycles while a second request waits
    @(negedge clk);
    req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = '0;
    req_valid = 1'b1;
    check("bp_ready_first", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h12345678;
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd2);
    w0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hBEEF7FFE);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    handshake();
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_after_ready", 32'(req_ready), 32'd1);
    check("bp_no_early_wr", 32'(wr_count - w0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("bp2_lat", 32'(lat), 32'd2);
    handshake();
    check("bp2_mem", mem[4], 32'h12345678);

    // Reset while a byte store sits in RMW_RD
    poke(7'd4, 32'h11223344);
    w0 = wr_count;
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_BYTE; req_addr = 32'h11; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_mem_addr", mem_addr, 32'h80);
    reset = 1'b1;
    #1;
    check("rmw_rst_we",    32'(mem_we), 32'd0);
    check("rmw_rst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rmw_rel_ready", 32'(req_ready), 32'd1);
    check("rmw_rel_valid", 32'(rsp_valid), 32'd0);
    check("rmw_no_write",  32'(wr_count - w0), 32'd0);
    check("rmw_mem",       mem[4], 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
